// File: rtl/adc_idelay_cal_if.sv
// Calibration-controller bus: start/training data in, IDELAYE3 tap control and status out.
// master = calibration controller, slave = the ADC capture path / system side.
interface adc_idelay_cal_if #(
    parameter int NUM_LANES = 8,
    parameter int TAP_W     = 9
);
    logic                         start;
    logic [2*NUM_LANES-1:0]       adc_data;
    logic [TAP_W-1:0]             cntvalue;
    logic [NUM_LANES-1:0]         load;
    logic                         en_vtc;
    logic                         busy;
    logic                         done;
    logic [NUM_LANES-1:0]         lane_fail;
    logic [NUM_LANES*TAP_W-1:0]   lane_tap;

    modport master (
        input  start, adc_data,
        output cntvalue, load, en_vtc, busy, done, lane_fail, lane_tap
    );

    modport slave (
        output start, adc_data,
        input  cntvalue, load, en_vtc, busy, done, lane_fail, lane_tap
    );
endinterface

// File: rtl/adc_idelay_cal.sv
// Per-lane IDELAYE3 tap sweep: finds the longest passing window and loads its centre.
// Optional: define ADC_CAL_RETRY_EN to rerun the whole calibration once if any lane fails.
module adc_idelay_cal #(
    parameter int                     NUM_LANES   = 8,
    parameter int                     TAP_W       = 9,
    parameter int                     MAX_TAP     = 511,
    parameter int                     SETTLE_CYC  = 8,
    parameter int                     SAMPLE_CNT  = 16,
    parameter logic [2*NUM_LANES-1:0] TRAIN_PAT   = 16'h5555,
    parameter int                     DEFAULT_TAP = 0
) (
    input  logic             clk,
    input  logic             rst,
    adc_idelay_cal_if.master bus
);
    localparam int LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CNT_MAX = (SETTLE_CYC > SAMPLE_CNT) ? SETTLE_CYC : SAMPLE_CNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLE_CNT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [TAP_W-1:0]  TAP_LAST    = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0]  TAP_ONE     = TAP_W'(1);
    localparam logic [TAP_W:0]    LEN_ONE     = (TAP_W+1)'(1);
    localparam logic [LANE_W-1:0] LANE_LAST   = LANE_W'(NUM_LANES - 1);
    localparam logic [LANE_W-1:0] LANE_ONE    = LANE_W'(1);

    localparam logic [3:0] S_IDLE         = 4'd0;
    localparam logic [3:0] S_VTC_OFF      = 4'd1;
    localparam logic [3:0] S_LOAD         = 4'd2;
    localparam logic [3:0] S_SETTLE       = 4'd3;
    localparam logic [3:0] S_SAMPLE       = 4'd4;
    localparam logic [3:0] S_EVAL         = 4'd5;
    localparam logic [3:0] S_FINAL_LOAD   = 4'd6;
    localparam logic [3:0] S_FINAL_SETTLE = 4'd7;
    localparam logic [3:0] S_NEXT_LANE    = 4'd8;
    localparam logic [3:0] S_VTC_ON       = 4'd9;

    logic [3:0]                 state_q, state_d;
    logic [LANE_W-1:0]          lane_q, lane_d;
    logic [TAP_W-1:0]           tap_q, tap_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       sample_pass_q, sample_pass_d;
    logic                       run_open_q, run_open_d;
    logic [TAP_W-1:0]           run_start_q, run_start_d;
    logic [TAP_W:0]             run_len_q, run_len_d;
    logic [TAP_W-1:0]           best_start_q, best_start_d;
    logic [TAP_W:0]             best_len_q, best_len_d;
    logic [TAP_W-1:0]           cntvalue_q, cntvalue_d;
    logic [NUM_LANES-1:0]       load_q, load_d;
    logic                       en_vtc_q, en_vtc_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [NUM_LANES-1:0]       lane_fail_q, lane_fail_d;
    logic [NUM_LANES*TAP_W-1:0] lane_tap_q, lane_tap_d;
    logic [TAP_W-1:0]           final_tap;
`ifdef ADC_CAL_RETRY_EN
    logic                       retry_q, retry_d;
`endif

    // Per-lane compare of the 2-bit DDR slice against the training pattern
    logic [NUM_LANES-1:0] lane_match;
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_match
            assign lane_match[gi] = (bus.adc_data[2*gi +: 2] == TRAIN_PAT[2*gi +: 2]);
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        lane_d        = lane_q;
        tap_d         = tap_q;
        cnt_d         = cnt_q;
        sample_pass_d = sample_pass_q;
        run_open_d    = run_open_q;
        run_start_d   = run_start_q;
        run_len_d     = run_len_q;
        best_start_d  = best_start_q;
        best_len_d    = best_len_q;
        cntvalue_d    = cntvalue_q;
        load_d        = '0;
        en_vtc_d      = en_vtc_q;
        busy_d        = busy_q;
        done_d        = done_q;
        lane_fail_d   = lane_fail_q;
        lane_tap_d    = lane_tap_q;
        final_tap     = '0;
`ifdef ADC_CAL_RETRY_EN
        retry_d       = retry_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d      = S_VTC_OFF;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    lane_fail_d  = '0;
                    en_vtc_d     = 1'b0;
                    lane_d       = '0;
                    tap_d        = '0;
                    cnt_d        = '0;
                    run_open_d   = 1'b0;
                    run_len_d    = '0;
                    best_len_d   = '0;
                    best_start_d = '0;
`ifdef ADC_CAL_RETRY_EN
                    retry_d      = 1'b0;
`endif
                end
            end
            S_VTC_OFF: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_SAMPLE: begin
                if (!lane_match[lane_q]) begin
                    sample_pass_d = 1'b0;
                    state_d       = S_EVAL;
                end else if (cnt_q == SAMPLE_LAST) begin
                    sample_pass_d = 1'b1;
                    state_d       = S_EVAL;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_EVAL: begin
                if (sample_pass_q) begin
                    if (!run_open_q) begin
                        run_start_d = tap_q;
                    end
                    run_open_d = 1'b1;
                    run_len_d  = run_len_q + LEN_ONE;
                end else begin
                    // run_len is zero when no run is open, so closing is unconditional
                    if (run_len_q > best_len_q) begin
                        best_len_d   = run_len_q;
                        best_start_d = run_start_q;
                    end
                    run_open_d = 1'b0;
                    run_len_d  = '0;
                end
                if (tap_q == TAP_LAST) begin
                    if (run_open_d && (run_len_d > best_len_d)) begin
                        best_len_d   = run_len_d;
                        best_start_d = run_start_d;
                    end
                    run_open_d = 1'b0;
                    run_len_d  = '0;
                    state_d    = S_FINAL_LOAD;
                end else begin
                    tap_d   = tap_q + TAP_ONE;
                    state_d = S_LOAD;
                end
            end
            S_FINAL_LOAD: begin
                cnt_d   = '0;
                state_d = S_FINAL_SETTLE;
            end
            S_FINAL_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_NEXT_LANE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_NEXT_LANE: begin
                run_open_d   = 1'b0;
                run_len_d    = '0;
                run_start_d  = '0;
                best_len_d   = '0;
                best_start_d = '0;
                if (lane_q == LANE_LAST) begin
                    state_d = S_VTC_ON;
                end else begin
                    lane_d  = lane_q + LANE_ONE;
                    tap_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_VTC_ON: begin
`ifdef ADC_CAL_RETRY_EN
                if ((|lane_fail_q) && !retry_q) begin
                    retry_d     = 1'b1;
                    lane_fail_d = '0;
                    lane_d      = '0;
                    tap_d       = '0;
                    cnt_d       = '0;
                    state_d     = S_VTC_OFF;
                end else begin
                    en_vtc_d = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
`else
                en_vtc_d = 1'b1;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                state_d  = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are registered on entry so they line up with the LOAD/FINAL_LOAD cycle
        if (state_d == S_LOAD) begin
            load_d     = NUM_LANES'(1) << lane_d;
            cntvalue_d = tap_d;
        end
        if (state_d == S_FINAL_LOAD) begin
            if (best_len_d != '0) begin
                final_tap = best_start_d + TAP_W'((best_len_d - LEN_ONE) >> 1);
            end else begin
                final_tap           = TAP_W'(DEFAULT_TAP);
                lane_fail_d[lane_d] = 1'b1;
            end
            load_d                           = NUM_LANES'(1) << lane_d;
            cntvalue_d                       = final_tap;
            lane_tap_d[TAP_W*lane_d +: TAP_W] = final_tap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            lane_q        <= '0;
            tap_q         <= '0;
            cnt_q         <= '0;
            sample_pass_q <= 1'b0;
            run_open_q    <= 1'b0;
            run_start_q   <= '0;
            run_len_q     <= '0;
            best_start_q  <= '0;
            best_len_q    <= '0;
            cntvalue_q    <= '0;
            load_q        <= '0;
            en_vtc_q      <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            lane_fail_q   <= '0;
            lane_tap_q    <= '0;
`ifdef ADC_CAL_RETRY_EN
            retry_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            lane_q        <= lane_d;
            tap_q         <= tap_d;
            cnt_q         <= cnt_d;
            sample_pass_q <= sample_pass_d;
            run_open_q    <= run_open_d;
            run_start_q   <= run_start_d;
            run_len_q     <= run_len_d;
            best_start_q  <= best_start_d;
            best_len_q    <= best_len_d;
            cntvalue_q    <= cntvalue_d;
            load_q        <= load_d;
            en_vtc_q      <= en_vtc_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            lane_fail_q   <= lane_fail_d;
            lane_tap_q    <= lane_tap_d;
`ifdef ADC_CAL_RETRY_EN
            retry_q       <= retry_d;
`endif
        end
    end

    assign bus.cntvalue  = cntvalue_q;
    assign bus.load      = load_q;
    assign bus.en_vtc    = en_vtc_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.lane_fail = lane_fail_q;
    assign bus.lane_tap  = lane_tap_q;
endmodule

// File: tb/tb_adc_idelay_cal.sv
// Bench for adc_idelay_cal: an IDELAY/ADC model returns the training pattern only at
// passing taps; results are checked against table constants and a window-search model.
module tb_adc_idelay_cal;
    localparam int          NL     = 8;
    localparam int          TW     = 9;
    localparam int          MAXT   = 63;
    localparam int          SET    = 2;
    localparam int          SMP    = 4;
    localparam logic [15:0] PAT    = 16'h5555;
    localparam int          LOADS1 = MAXT + 2;
    localparam int          BUDGET = 12000;
`ifdef ADC_CAL_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    typedef struct packed {
        logic [NL-1:0][63:0]   m1;
        logic [NL-1:0][63:0]   m2;
        logic [NL-1:0]         ef;
        logic [NL-1:0][TW-1:0] et;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adc_idelay_cal_if #(.NUM_LANES(NL), .TAP_W(TW)) bus ();

    adc_idelay_cal #(
        .NUM_LANES(NL), .TAP_W(TW), .MAX_TAP(MAXT), .SETTLE_CYC(SET),
        .SAMPLE_CNT(SMP), .TRAIN_PAT(PAT), .DEFAULT_TAP(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [NL-1:0][63:0] mask1, mask2;
    logic [TW-1:0]       lane_delay [NL] = '{default: '0};
    int                  load_cnt   [NL] = '{default: 0};
    int                  onehot_viol = 0;
    int                  hold_viol   = 0;
    logic [TW-1:0]       prev_cv     = '0;
    bit                  cnt_clr     = 1'b0;
    int                  checks, errors;

    // IDELAY model: a lane latches the shared tap bus on its LOAD strobe
    always @(posedge clk) begin
        if (cnt_clr) begin
            load_cnt    <= '{default: 0};
            onehot_viol <= 0;
            hold_viol   <= 0;
        end else begin
            if ($countones(bus.load) > 1) onehot_viol <= onehot_viol + 1;
            if (bus.load == '0 && bus.cntvalue != prev_cv) hold_viol <= hold_viol + 1;
            for (int i = 0; i < NL; i++) begin
                if (bus.load[i]) begin
                    lane_delay[i] <= bus.cntvalue;
                    load_cnt[i]   <= load_cnt[i] + 1;
                end
            end
        end
        prev_cv <= bus.cntvalue;
    end

    // ADC model: pass-2 mask applies once a lane has seen more than one pass of loads
    always_comb begin
        bus.adc_data = PAT;
        for (int i = 0; i < NL; i++) begin
            if (!((load_cnt[i] > LOADS1) ? mask2[i][lane_delay[i][5:0]]
                                         : mask1[i][lane_delay[i][5:0]]))
                bus.adc_data[2*i +: 2] = ~PAT[2*i +: 2];
        end
    end

    function automatic logic [63:0] win(input int lo, input int hi);
        logic [63:0] r;
        r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    // Longest run of passing taps, earliest on ties, centre rounded down
    function automatic void model(input logic [63:0] m, output logic f, output logic [TW-1:0] t);
        int best_len;
        int best_s;
        int l;
        best_len = 0;
        best_s   = 0;
        for (int s = 0; s <= MAXT; s++) begin
            if (m[s] && ((s == 0) ? 1'b1 : !m[s-1])) begin
                l = 0;
                while (s + l <= MAXT && m[s+l]) l++;
                if (l > best_len) begin
                    best_len = l;
                    best_s   = s;
                end
            end
        end
        f = (best_len == 0);
        t = f ? '0 : TW'(best_s + (best_len - 1) / 2);
    endfunction

    function automatic int exp_loads(input logic [NL-1:0][63:0] m);
        bit any_dead;
        any_dead = 1'b0;
        for (int i = 0; i < NL; i++) if (m[i] == '0) any_dead = 1'b1;
        return (RETRY_EN && any_dead) ? 2 * LOADS1 : LOADS1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_cal(input string nm, input logic [NL-1:0][63:0] m1, input logic [NL-1:0][63:0] m2,
                          input logic [NL-1:0] ef, input logic [NL-1:0][TW-1:0] et,
                          input int el, input bit extra_start);
        int cyc;
        int drop;
        @(negedge clk);
        mask1   = m1;
        mask2   = m2;
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr   = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk({nm, "_busy_after_start"}, 32'(bus.busy), 32'd1);
        chk({nm, "_done_after_start"}, 32'(bus.done), 32'd0);
        chk({nm, "_envtc_low"}, 32'(bus.en_vtc), 32'd0);
        cyc  = 0;
        drop = 0;
        while (!bus.done && cyc < BUDGET) begin
            if (!bus.busy) drop++;
            bus.start = (extra_start && cyc == 50);
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        chk({nm, "_finished_in_budget"}, 32'(cyc < BUDGET), 32'd1);
        chk({nm, "_done"}, 32'(bus.done), 32'd1);
        chk({nm, "_busy_end"}, 32'(bus.busy), 32'd0);
        chk({nm, "_envtc_end"}, 32'(bus.en_vtc), 32'd1);
        chk({nm, "_busy_span"}, 32'(drop), 32'd0);
        chk({nm, "_lane_fail"}, 32'(bus.lane_fail), 32'(ef));
        for (int i = 0; i < NL; i++) begin
            chk($sformatf("%s_tap%0d", nm, i), 32'(bus.lane_tap[TW*i +: TW]), 32'(et[i]));
            chk($sformatf("%s_loads%0d", nm, i), 32'(load_cnt[i]), 32'(el));
        end
        chk({nm, "_onehot"}, 32'(onehot_viol), 32'd0);
        chk({nm, "_cnt_hold"}, 32'(hold_viol), 32'd0);
        $display("tb: %s cycles=%0d lane_fail=%02h lane_tap0=%0d", nm, cyc, bus.lane_fail,
                 bus.lane_tap[TW-1:0]);
    endtask

    vec_t  tbl   [7];
    string names [7];

    initial begin
        vec_t v;
        int   cyc;
        logic f;
        logic [TW-1:0] t;
        int   lo;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        mask1     = '0;
        mask2     = '0;
        repeat (3) @(negedge clk);
        chk("rst_cntvalue", 32'(bus.cntvalue), 32'd0);
        chk("rst_load", 32'(bus.load), 32'd0);
        chk("rst_en_vtc", 32'(bus.en_vtc), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_lane_fail", 32'(bus.lane_fail), 32'd0);
        chk("rst_lane_tap", 32'(bus.lane_tap != '0), 32'd0);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) begin
            tbl[k].m1 = {NL{win(10, 30)}};
            tbl[k].ef = '0;
            tbl[k].et = {NL{9'd20}};
        end
        names[0] = "all_pass";
        names[1] = "lane3_dead";
        tbl[1].m1[3] = '0;
        tbl[1].ef    = 8'h08;
        tbl[1].et[3] = 9'd0;
        names[2] = "two_windows";
        tbl[2].m1[0] = win(10, 20) | win(30, 50);
        tbl[2].et[0] = 9'd40;
        names[3] = "tie_windows";
        tbl[3].m1[0] = win(10, 20) | win(30, 40);
        tbl[3].et[0] = 9'd15;
        names[4] = "max_edge";
        tbl[4].m1[5] = win(50, 63);
        tbl[4].et[5] = 9'd56;
        names[5] = "single_tap";
        tbl[5].m1[0] = win(7, 7);
        tbl[5].et[0] = 9'd7;
        for (int k = 0; k < 6; k++) tbl[k].m2 = tbl[k].m1;
        names[6] = "retry";
        tbl[6].m1[1] = '0;
        tbl[6].m2    = {NL{win(10, 30)}};
        tbl[6].m2[1] = win(20, 40);
        if (RETRY_EN) begin
            tbl[6].ef    = 8'h00;
            tbl[6].et[1] = 9'd30;
        end else begin
            tbl[6].ef    = 8'h02;
            tbl[6].et[1] = 9'd0;
        end

        for (int k = 0; k < 7; k++)
            do_cal(names[k], tbl[k].m1, tbl[k].m2, tbl[k].ef, tbl[k].et, exp_loads(tbl[k].m1), 1'b0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NL; i++) begin
                v.m1[i] = '0;
                for (int w = $urandom_range(0, 3); w > 0; w--) begin
                    lo = $urandom_range(0, MAXT);
                    v.m1[i] = v.m1[i] | win(lo, (lo + $urandom_range(0, 19) > MAXT) ? MAXT
                                                  : lo + $urandom_range(0, 19));
                end
                model(v.m1[i], f, t);
                v.ef[i] = f;
                v.et[i] = t;
            end
            v.m2 = v.m1;
            do_cal($sformatf("random%0d", r), v.m1, v.m2, v.ef, v.et, exp_loads(v.m1), 1'b0);
        end

        // Abort mid-sweep on lane 2, then a full rerun with a stray start while busy
        @(negedge clk);
        mask1     = {NL{win(10, 30)}};
        mask2     = mask1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.load[2] && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_mid_reached_lane2", 32'(bus.load[2]), 32'd1);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_en_vtc", 32'(bus.en_vtc), 32'd1);
        chk("rst_mid_load", 32'(bus.load), 32'd0);
        chk("rst_mid_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        do_cal("restart_full", {NL{win(10, 30)}}, {NL{win(10, 30)}}, '0, {NL{9'd20}}, LOADS1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
